sha256_mem_host: RTL and testbench
==================================

SHA256_MEM_HOST -- requirements
Module: sha256_mem_host

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20: message words loaded per job.
REQ-002 SHALL have parameter MEM_DEPTH, default 256: words of internal memory, addresses 0..MEM_DEPTH-1.
REQ-003 SHALL have parameter MSG_BASE, default 16'h0000: word address of message word 0.
REQ-004 SHALL have parameter OUT_BASE, default 16'h0080: word address of hash word h0.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit, used only under the macro.
REQ-006 SHALL have ports:
  clk  in  1  single clock; reset is synchronous and active-high
  reset  in  1  synchronous active-high reset
  in_valid  in  1  host message word valid
  in_ready  out  1  host word accepted when in_valid & in_ready
  in_data  in  32  message word
  start  out  1  one-cycle job start to hasher
  done  in  1  hasher done level
  message_addr  out  16  constant MSG_BASE
  output_addr  out  16  constant OUT_BASE
  mem_we  in  1  hasher write enable
  mem_addr  in  16  hasher word address
  mem_write_data  in  32  hasher write data
  mem_read_data  out  32  read data to hasher
  out_valid  out  1  hash word valid
  out_ready  in  1  hash word consumed when out_valid & out_ready
  out_data  out  32  hash word, h0 first
  out_last  out  1  high with the 8th hash word
  busy  out  1  state != IDLE
  err  out  1  sticky out-of-range access flag

Function
REQ-007 SHALL implement FSM IDLE, LOAD, START, WAIT, DRAIN.
REQ-008 IDLE: in_ready=1; an accepted word SHALL be written to MSG_BASE+0, count=1, next state LOAD; if NUM_OF_WORDS=1, next state START instead.
REQ-009 LOAD: in_ready=1; the k-th accepted word SHALL be written to MSG_BASE+k; the word that makes count=NUM_OF_WORDS SHALL go to START.
REQ-010 START: start=1 for exactly one cycle, in_ready=0, next state WAIT.
REQ-011 WAIT: serve the hasher: mem_read_data <= mem[mem_addr] every clock (1-cycle registered read latency); if mem_we=1, mem[mem_addr] <= mem_write_data on that edge.
REQ-012 Read-during-write to the same address in WAIT SHALL return the old data.
REQ-013 WAIT SHALL leave only on a done rising edge (done=1 with registered done=0); a done level held over from a previous job SHALL be ignored.
REQ-014 DRAIN: read OUT_BASE+0..7 through the internal port and present each word on out_data with out_valid=1; out_data/out_valid SHALL stay stable until out_ready=1; zero bubbles when out_ready is held high.
REQ-015 out_last=1 only with word 7; its acceptance SHALL return to IDLE.
REQ-016 mem_we/mem_addr SHALL be ignored outside WAIT; mem_read_data SHALL hold its last value outside WAIT.
REQ-017 Address >= MEM_DEPTH: write dropped, read returns 32'h0, err set until reset.
REQ-018 in_valid outside IDLE/LOAD SHALL be ignored with no data loss (in_ready=0).

Reset
REQ-019 While reset=1 at a clock edge: state=IDLE, count=0, start=0, out_valid=0, out_last=0, out_data=0, mem_read_data=0, err=0, busy=0.
REQ-020 Reset mid-job SHALL abort to IDLE within one clock; memory contents SHALL NOT be cleared.

Configuration
REQ-021 Macro SHA_HOST_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES with no done rising edge SHALL set err and go to IDLE without draining.
REQ-022 Macro undefined: no counter; WAIT waits for done indefinitely.

Structure
REQ-023 Package sha256_host_pkg SHALL hold the state enum typedef, HASH_WORDS=8 and the default base addresses.
REQ-024 Memory array SHALL be one sub-module, sha256_host_ram: one write port and one registered read port; muxing between hasher and drain is done in the top level.

Verification
REQ-025 Load 20 words 32'h00000001..32'h00000014 -> mem[0..19] hold those values, one start pulse 1 cycle after the 20th accept.
REQ-026 Hasher model reads addr 5 in WAIT -> mem_read_data=32'h00000006 on the next cycle.
REQ-027 Model writes h0..h7=32'hA0..A7 to 0x80..0x87, pulses done; out_ready=1 -> 8 consecutive out words A0..A7, out_last with A7, then IDLE.
REQ-028 out_ready toggles 1,0,0,1 during DRAIN -> out_data held while stalled; no word duplicated or dropped.
REQ-029 done held high from the previous job at WAIT entry -> FSM stays in WAIT until done falls and rises again.
REQ-030 Write to address 0x0100 with MEM_DEPTH=256 -> no array change, err=1; reset during WAIT -> IDLE next cycle; with SHA_HOST_TIMEOUT_EN and no done -> err=1, IDLE after 4096 cycles.

Source files
------------

// File: rtl/sha256_host_pkg.sv
// sha256_host_pkg: state type and default address map shared by the SHA-256 memory host.
package sha256_host_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;
    localparam int          HASH_WORDS   = 8;
    localparam logic [15:0] DEF_MSG_BASE = 16'h0000;
    localparam logic [15:0] DEF_OUT_BASE = 16'h0080;
endpackage

// File: rtl/sha256_host_ram.sv
// sha256_host_ram: single write port, registered read port; a same-address write returns old data.
module sha256_host_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sha256_mem_host.sv
// sha256_mem_host: loads message words, hands the memory to a hasher, then streams out the 8 hash words.
// Optional watchdog on the hasher wait is enabled with SHA_HOST_TIMEOUT_EN.
module sha256_mem_host
    import sha256_host_pkg::*;
#(
    parameter int          NUM_OF_WORDS   = 20,
    parameter int          MEM_DEPTH      = 256,
    parameter logic [15:0] MSG_BASE       = DEF_MSG_BASE,
    parameter logic [15:0] OUT_BASE       = DEF_OUT_BASE,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        start,
    input  logic        done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err
);
    localparam int          AW       = $clog2(MEM_DEPTH);
    localparam logic [16:0] DEPTH17  = 17'(MEM_DEPTH);
    localparam logic [15:0] CNT_LAST = 16'(NUM_OF_WORDS - 1);
    localparam logic [3:0]  IDX_LAST = 4'(HASH_WORDS - 1);

    state_t      r_state, w_state_nx;
    logic [15:0] r_count;
    logic [3:0]  r_idx, w_next_idx;
    logic        r_out_valid, r_done_q, r_err, r_rd_wait, r_rd_oor;
    logic [31:0] r_hold, w_ram_rdata, w_rdata, w_wdata;
    logic [15:0] w_waddr, w_raddr;
    logic        w_acc, w_fire, w_done_rise, w_tmo, w_we, w_wr_oor, w_rd_oor;

    assign w_acc         = in_valid & in_ready;
    assign w_fire        = out_valid & out_ready;
    assign w_done_rise   = done & ~r_done_q;
    // Drain re-reads the presented word while stalled, so the read port itself holds out_data.
    assign w_next_idx    = w_fire ? r_idx + 4'd1 : r_idx;
    assign w_wr_oor      = {1'b0, w_waddr} >= DEPTH17;
    assign w_rd_oor      = {1'b0, w_raddr} >= DEPTH17;
    assign w_rdata       = r_rd_oor ? 32'h0 : w_ram_rdata;
    assign out_valid     = r_out_valid;
    assign out_last      = r_out_valid & (r_idx == IDX_LAST);
    assign out_data      = r_out_valid ? w_rdata : 32'h0;
    assign mem_read_data = r_rd_wait ? w_rdata : r_hold;
    assign busy          = r_state != S_IDLE;
    assign err           = r_err;
    assign message_addr  = MSG_BASE;
    assign output_addr   = OUT_BASE;

    always_comb begin
        w_waddr = mem_addr;
        w_wdata = mem_write_data;
        w_we    = 1'b0;
        w_raddr = OUT_BASE + {12'd0, w_next_idx};
        if (r_state == S_WAIT) begin
            w_we    = mem_we;
            w_raddr = mem_addr;
        end else if (w_acc) begin
            w_waddr = MSG_BASE + r_count;
            w_wdata = in_data;
            w_we    = 1'b1;
        end
    end

    sha256_host_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_we & ~w_wr_oor),
        .i_waddr (w_waddr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr[AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

`ifdef SHA_HOST_TIMEOUT_EN
    logic [31:0] r_tmo;
    always_ff @(posedge clk) r_tmo <= (reset || r_state != S_WAIT) ? 32'd0 : r_tmo + 32'd1;
    assign w_tmo = r_tmo == 32'(TIMEOUT_CYCLES - 1);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_state_nx;

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nx = (NUM_OF_WORDS == 1) ? S_START : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_count == CNT_LAST) w_state_nx = S_START;
            end
            S_START: begin
                start      = 1'b1;
                w_state_nx = S_WAIT;
            end
            S_WAIT:  w_state_nx = w_done_rise ? S_DRAIN : (w_tmo ? S_IDLE : S_WAIT);
            S_DRAIN: w_state_nx = (w_fire && out_last) ? S_IDLE : S_DRAIN;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_done_q    <= 1'b0;
            r_err       <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_done_q    <= done;
            r_rd_wait   <= r_state == S_WAIT;
            r_rd_oor    <= w_rd_oor;
            r_hold      <= mem_read_data;
            r_count     <= (r_state == S_START) ? 16'd0 : r_count + {15'd0, w_acc};
            r_idx       <= (r_state == S_DRAIN) ? w_next_idx : 4'd0;
            r_out_valid <= (r_state == S_DRAIN) && !(w_fire && out_last);
            if (r_state == S_WAIT && (w_rd_oor || (w_tmo && !w_done_rise))) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sha256_mem_host.sv
// tb_sha256_mem_host: randomized jobs checked against a plain memory-array model of the host.
`timescale 1ns/1ps
module tb_sha256_mem_host;
    localparam int NW = 20;

    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, done = 1'b0, mem_we = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0, mem_write_data = '0;
    logic [15:0] mem_addr = '0;
    logic        in_ready, start, out_valid, out_last, busy, err;
    logic [15:0] message_addr, output_addr;
    logic [31:0] mem_read_data, out_data;

    logic [31:0] model [256];
    bit          known [256];
    logic [31:0] last_rd = '0;
    logic        exp_err = 1'b0;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    sha256_mem_host dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start(start), .done(done), .message_addr(message_addr), .output_addr(output_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One hasher cycle in WAIT: registered read of the pre-write contents.
    task automatic hcyc(input logic [15:0] a, input logic w, input logic [31:0] d);
        logic [31:0] e;
        bit          k;
        k = (a >= 16'd256) || known[a[7:0]];
        e = (a >= 16'd256) ? 32'h0 : model[a[7:0]];
        if (a >= 16'd256) exp_err = 1'b1;
        else if (w) begin
            model[a[7:0]] = d;
            known[a[7:0]] = 1'b1;
        end
        mem_addr = a; mem_we = w; mem_write_data = d;
        @(negedge clk);
        if (k) check("rd_data", mem_read_data, e);
        check("err", 32'(err), 32'(exp_err));
        last_rd = e;
    endtask

    task automatic load(input bit seq);
        int          k = 0;
        logic [31:0] v;
        while (k < NW) begin
            if (!seq && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end else begin
                v = seq ? 32'(k + 1) : $urandom;
                in_valid = 1'b1; in_data = v;
                model[k] = v; known[k] = 1'b1;
                check("in_ready", 32'(in_ready), 1);
                @(negedge clk);
                k++;
            end
        end
        in_data = 32'hDEADBEEF;
        check("start", 32'(start), 1);
        check("start_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("start_once", 32'(start), 0);
        check("wait_in_ready", 32'(in_ready), 0);
    endtask

    task automatic drain(input int mode);
        int         idx = 0, cyc = 0;
        logic [3:0] pat = 4'b1001;
        bit         was_stalled = 1'b0;
        mem_we = 1'b1; mem_addr = 16'h0085; mem_write_data = 32'hBAD0BAD0;
        while (idx < 8 && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3 - (cyc % 4)] : 1'($urandom_range(0, 1));
            if (was_stalled) check("stall_valid", 32'(out_valid), 1);
            if (out_valid) begin
                check($sformatf("out_data%0d", idx), out_data, model[8'h80 + 8'(idx)]);
                check("out_last", 32'(out_last), 32'(idx == 7));
            end
            check("hold_rd", mem_read_data, last_rd);
            was_stalled = out_valid && !out_ready;
            if (out_valid && out_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        mem_we = 1'b0; out_ready = 1'b0;
        check("drain_words", 32'(idx), 8);
        check("end_busy", 32'(busy), 0);
        check("end_valid", 32'(out_valid), 0);
        check("end_in_ready", 32'(in_ready), 1);
        if (mode == 0) check("no_bubble_cycles", 32'(cyc), 9);
    endtask

    function automatic logic [15:0] raddr();
        logic [5:0] v;
        v = 6'($urandom_range(0, 63));
        return v[5] ? 16'h0080 + {11'd0, v[4:0]} : {11'd0, v[4:0]};
    endfunction

    task automatic job(input bit seq, input bit held, input bit keep, input int mode, input bit oor);
        load(seq);
        if (held) begin
            repeat (4) begin
                hcyc(16'($urandom_range(0, NW - 1)), 1'b0, 32'h0);
                check("held_no_drain", 32'(out_valid), 0);
                check("held_busy", 32'(busy), 1);
            end
            done = 1'b0;
            hcyc(16'd1, 1'b0, 32'h0);
        end
        hcyc(16'd5, 1'b0, 32'h0);
        if (seq) check("rd_addr5", mem_read_data, 32'h6);
        for (int i = 0; i < NW; i++) hcyc(16'(i), 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) hcyc(16'h0080 + 16'(i), 1'b0, 32'h0);
        repeat (12) hcyc(raddr(), 1'($urandom_range(0, 1)), $urandom);
        if (oor) begin
            hcyc(16'h0100, 1'b1, $urandom);
            hcyc(16'h0100, 1'b0, 32'h0);
            hcyc(16'h0000, 1'b0, 32'h0);
            hcyc(16'hFFFF, 1'b1, $urandom);
        end
        for (int i = 0; i < 8; i++) hcyc(16'h0080 + 16'(i), 1'b1, seq ? 32'hA0 + 32'(i) : $urandom);
        done = 1'b1;
        hcyc(16'd0, 1'b0, 32'h0);
        if (!keep) done = 1'b0;
        drain(mode);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(start), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_data", out_data, 0);
        check("rst_rd_data", mem_read_data, 0);
        check("rst_err", 32'(err), 0);
        check("message_addr", 32'(message_addr), 32'h0000);
        check("output_addr", 32'(output_addr), 32'h0080);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 1);

        job(1'b1, 1'b0, 1'b1, 0, 1'b0);
        job(1'b0, 1'b1, 1'b0, 1, 1'b0);
        job(1'b0, 1'b0, 1'b0, 2, 1'b1);

        load(1'b0);
        hcyc(16'd2, 1'b0, 32'h0);
        hcyc(16'd7, 1'b1, $urandom);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_we = 1'b0;
        exp_err = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_rd_data", mem_read_data, 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_start", 32'(start), 0);
        check("midrst_in_ready", 32'(in_ready), 1);

        job(1'b0, 1'b0, 1'b0, 2, 1'b0);
        job(1'b0, 1'b0, 1'b0, 0, 1'b0);

`ifdef SHA_HOST_TIMEOUT_EN
        load(1'b0);
        mem_addr = 16'd0; mem_we = 1'b0;
        repeat (4095) @(negedge clk);
        check("tmo_still_wait", 32'(busy), 1);
        @(negedge clk);
        check("tmo_idle", 32'(busy), 0);
        check("tmo_err", 32'(err), 1);
        check("tmo_no_drain", 32'(out_valid), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
